// File: rtl/dsi_lp_escape_lane.sv
`default_nettype none
// ============================================================================
// Module   : dsi_lp_escape_lane
// Brief    : D-PHY data-lane LP escape-mode transmitter (LPDT, ULPS, triggers)
// Revision : 1.0 - initial release
// ============================================================================
module dsi_lp_escape_lane #(
  parameter int unsigned T_LPX_CYC      = 4,
  parameter int unsigned T_WAKEUP_CYC   = 16,
  parameter logic [7:0]  CMD_LPDT       = 8'b11100001,
  parameter logic [7:0]  CMD_ULPS       = 8'b00011110,
  parameter logic [7:0]  CMD_RESET_TRIG = 8'b01100010
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_user,
  input  logic       ulps_exit,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       in_ulps,
  output logic       done,
  output logic       err_underrun,
  output logic       lp_p,
  output logic       lp_n,
  output logic       lp_oe
);

  localparam logic [7:0]  c_phase_reload = 8'(T_LPX_CYC - 1);
  localparam logic [15:0] c_wake_reload  = 16'(T_WAKEUP_CYC - 1);

  typedef enum logic [2:0] {
    S_DISABLED  = 3'd0,
    S_STOP      = 3'd1,
    S_ESC_ENTRY = 3'd2,
    S_CMD       = 3'd3,
    S_DATA      = 3'd4,
    S_EXIT      = 3'd5,
    S_ULPS      = 3'd6,
    S_WAKE      = 3'd7
  } state_t;

  state_t      r_state, w_nxt_state;
  logic [7:0]  r_phase_cnt, w_nxt_phase_cnt;
  logic [1:0]  r_sub, w_nxt_sub;
  logic [2:0]  r_bit_cnt, w_nxt_bit_cnt;
  logic [15:0] r_wake_cnt, w_nxt_wake_cnt;
  logic [7:0]  r_shift, w_nxt_shift;
  logic [7:0]  r_cmd, w_nxt_cmd;
  logic        r_is_lpdt, w_nxt_is_lpdt;
  logic        r_is_ulps, w_nxt_is_ulps;
  logic [7:0]  r_hold_data, w_nxt_hold_data;
  logic        r_hold_full, w_nxt_hold_full;
  logic        r_hold_last, w_nxt_hold_last;
  logic        r_last_loaded, w_nxt_last_loaded;
  logic        r_last_accepted, w_nxt_last_accepted;

  logic        r_tx_ready, w_nxt_tx_ready;
  logic        r_busy, w_nxt_busy;
  logic        r_in_ulps, w_nxt_in_ulps;
  logic        r_done, w_nxt_done;
  logic        r_err_underrun, w_nxt_err_underrun;
  logic [1:0]  r_line, w_nxt_line;
  logic        r_lp_oe, w_nxt_lp_oe;

  logic        w_phase_end;
  logic        w_load;
  logic        w_accept;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_DISABLED;
      r_phase_cnt     <= 8'd0;
      r_sub           <= 2'd0;
      r_bit_cnt       <= 3'd0;
      r_wake_cnt      <= 16'd0;
      r_shift         <= 8'd0;
      r_cmd           <= 8'd0;
      r_is_lpdt       <= 1'b0;
      r_is_ulps       <= 1'b0;
      r_hold_data     <= 8'd0;
      r_hold_full     <= 1'b0;
      r_hold_last     <= 1'b0;
      r_last_loaded   <= 1'b0;
      r_last_accepted <= 1'b0;
      r_tx_ready      <= 1'b0;
      r_busy          <= 1'b0;
      r_in_ulps       <= 1'b0;
      r_done          <= 1'b0;
      r_err_underrun  <= 1'b0;
      r_line          <= 2'b11;
      r_lp_oe         <= 1'b0;
    end else begin
      r_state         <= w_nxt_state;
      r_phase_cnt     <= w_nxt_phase_cnt;
      r_sub           <= w_nxt_sub;
      r_bit_cnt       <= w_nxt_bit_cnt;
      r_wake_cnt      <= w_nxt_wake_cnt;
      r_shift         <= w_nxt_shift;
      r_cmd           <= w_nxt_cmd;
      r_is_lpdt       <= w_nxt_is_lpdt;
      r_is_ulps       <= w_nxt_is_ulps;
      r_hold_data     <= w_nxt_hold_data;
      r_hold_full     <= w_nxt_hold_full;
      r_hold_last     <= w_nxt_hold_last;
      r_last_loaded   <= w_nxt_last_loaded;
      r_last_accepted <= w_nxt_last_accepted;
      r_tx_ready      <= w_nxt_tx_ready;
      r_busy          <= w_nxt_busy;
      r_in_ulps       <= w_nxt_in_ulps;
      r_done          <= w_nxt_done;
      r_err_underrun  <= w_nxt_err_underrun;
      r_line          <= w_nxt_line;
      r_lp_oe         <= w_nxt_lp_oe;
    end
  end

  always_comb begin
    w_nxt_state        = r_state;
    w_nxt_phase_cnt    = r_phase_cnt - 8'd1;
    w_nxt_sub          = r_sub;
    w_nxt_bit_cnt      = r_bit_cnt;
    w_nxt_wake_cnt     = r_wake_cnt;
    w_nxt_shift        = r_shift;
    w_nxt_cmd          = r_cmd;
    w_nxt_is_lpdt      = r_is_lpdt;
    w_nxt_is_ulps      = r_is_ulps;
    w_nxt_last_loaded  = r_last_loaded;
    w_nxt_done         = 1'b0;
    w_nxt_err_underrun = 1'b0;
    w_load             = 1'b0;
    w_phase_end        = (r_phase_cnt == 8'd0);
    w_accept           = tx_valid & r_tx_ready;

    case (r_state)
      S_DISABLED: begin
        if (enable) w_nxt_state = S_STOP;
      end
      S_STOP: begin
        if (!enable) begin
          w_nxt_state = S_DISABLED;
        end else if (start) begin
          w_nxt_state       = S_ESC_ENTRY;
          w_nxt_sub         = 2'd0;
          w_nxt_phase_cnt   = c_phase_reload;
          w_nxt_last_loaded = 1'b0;
          w_nxt_is_lpdt     = (cmd_sel == 2'd0);
          w_nxt_is_ulps     = (cmd_sel == 2'd1);
          case (cmd_sel)
            2'd0:    w_nxt_cmd = CMD_LPDT;
            2'd1:    w_nxt_cmd = CMD_ULPS;
            2'd2:    w_nxt_cmd = CMD_RESET_TRIG;
            default: w_nxt_cmd = cmd_user;
          endcase
        end
      end
      S_ESC_ENTRY: begin
        if (w_phase_end) begin
          w_nxt_phase_cnt = c_phase_reload;
          if (r_sub == 2'd3) begin
            w_nxt_state   = S_CMD;
            w_nxt_sub     = 2'd0;
            w_nxt_bit_cnt = 3'd0;
            w_nxt_shift   = r_cmd;
          end else begin
            w_nxt_sub = r_sub + 2'd1;
          end
        end
      end
      S_CMD, S_DATA: begin
        // sub 0 is the mark phase, sub 1 the separating space
        if (w_phase_end) begin
          w_nxt_phase_cnt = c_phase_reload;
          if (r_sub == 2'd0) begin
            w_nxt_sub = 2'd1;
          end else begin
            w_nxt_sub     = 2'd0;
            w_nxt_bit_cnt = r_bit_cnt + 3'd1;
            w_nxt_shift   = {r_shift[6:0], 1'b0};
            if (r_bit_cnt == 3'd7) begin
              if (r_state == S_CMD && r_is_ulps) begin
                w_nxt_state = S_ULPS;
              end else if (r_state == S_CMD && !r_is_lpdt) begin
                w_nxt_state = S_EXIT;
              end else if (r_state == S_DATA && r_last_loaded) begin
                w_nxt_state = S_EXIT;
              end else if (r_hold_full) begin
                w_nxt_state       = S_DATA;
                w_nxt_shift       = r_hold_data;
                w_nxt_last_loaded = r_hold_last;
                w_load            = 1'b1;
              end else begin
                w_nxt_state        = S_EXIT;
                w_nxt_err_underrun = 1'b1;
              end
            end
          end
        end
      end
      S_EXIT: begin
        if (w_phase_end) begin
          w_nxt_phase_cnt = c_phase_reload;
          if (r_sub == 2'd0) begin
            w_nxt_sub = 2'd1;
          end else begin
            w_nxt_state = S_STOP;
            w_nxt_done  = 1'b1;
          end
        end
      end
      S_ULPS: begin
        if (ulps_exit) begin
          w_nxt_state    = S_WAKE;
          w_nxt_wake_cnt = c_wake_reload;
        end
      end
      S_WAKE: begin
        if (r_wake_cnt == 16'd0) begin
          w_nxt_state = S_STOP;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_wake_cnt = r_wake_cnt - 16'd1;
        end
      end
      default: w_nxt_state = S_DISABLED;
    endcase

    // Holding register and last-byte bookkeeping are wiped whenever the lane returns to STOP
    w_nxt_hold_full     = (w_accept | (r_hold_full & ~w_load)) & (w_nxt_state != S_STOP);
    w_nxt_hold_data     = w_accept ? tx_data : r_hold_data;
    w_nxt_hold_last     = w_accept ? tx_last : r_hold_last;
    w_nxt_last_accepted = (r_last_accepted | (w_accept & tx_last)) & (w_nxt_state != S_STOP);

    w_nxt_tx_ready = ((w_nxt_state == S_CMD && w_nxt_is_lpdt) || w_nxt_state == S_DATA)
                     && !w_nxt_hold_full && !w_nxt_last_accepted;
    w_nxt_busy     = (w_nxt_state != S_DISABLED) && (w_nxt_state != S_STOP);
    w_nxt_in_ulps  = (w_nxt_state == S_ULPS);
    w_nxt_lp_oe    = (w_nxt_state != S_DISABLED);

    w_nxt_line = 2'b11;
    case (w_nxt_state)
      S_ESC_ENTRY: begin
        case (w_nxt_sub)
          2'd0:    w_nxt_line = 2'b10;
          2'd2:    w_nxt_line = 2'b01;
          default: w_nxt_line = 2'b00;
        endcase
      end
      S_CMD, S_DATA: begin
        if (w_nxt_sub == 2'd0) w_nxt_line = w_nxt_shift[7] ? 2'b10 : 2'b01;
        else                   w_nxt_line = 2'b00;
      end
      S_EXIT:  w_nxt_line = (w_nxt_sub == 2'd0) ? 2'b00 : 2'b10;
      S_ULPS:  w_nxt_line = 2'b00;
      S_WAKE:  w_nxt_line = 2'b10;
      default: w_nxt_line = 2'b11;
    endcase
  end

  assign tx_ready     = r_tx_ready;
  assign busy         = r_busy;
  assign in_ulps      = r_in_ulps;
  assign done         = r_done;
  assign err_underrun = r_err_underrun;
  assign lp_p         = r_line[1];
  assign lp_n         = r_line[0];
  assign lp_oe        = r_lp_oe;

endmodule
`default_nettype wire

// File: tb/tb_dsi_lp_escape_lane.sv
`default_nettype none
// Directed escape-mode sequences; the LP lines are compared run-by-run against
// an expected-run queue filled as each command and payload byte is driven.
module tb_dsi_lp_escape_lane;

  localparam int c_t_lpx  = 4;
  localparam int c_t_wake = 16;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd_sel = 2'd0;
  logic [7:0] cmd_user = 8'd0;
  logic       ulps_exit = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, busy, in_ulps, done, err_underrun, lp_p, lp_n, lp_oe;

  dsi_lp_escape_lane #(
    .T_LPX_CYC    (c_t_lpx),
    .T_WAKEUP_CYC (c_t_wake)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .enable       (enable),
    .start        (start),
    .cmd_sel      (cmd_sel),
    .cmd_user     (cmd_user),
    .ulps_exit    (ulps_exit),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .in_ulps      (in_ulps),
    .done         (done),
    .err_underrun (err_underrun),
    .lp_p         (lp_p),
    .lp_n         (lp_n),
    .lp_oe        (lp_oe)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]  lvl;
    logic [15:0] len;
  } run_t;

  run_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   err_cnt = 0;
  int   err_cyc = 0;
  logic watch_ready = 1'b0;
  logic ready_hi = 1'b0;
  logic [1:0] cur_lvl = 2'b11;
  int   cur_len = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input logic [1:0] lvl, input int len);
    run_t r;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].lvl == lvl) begin
      r = exp_q.pop_back();
      r.len = r.len + 16'(len);
    end else begin
      r.lvl = lvl;
      r.len = 16'(len);
    end
    exp_q.push_back(r);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      push_run(b[i] ? 2'b10 : 2'b01, c_t_lpx);
      push_run(2'b00, c_t_lpx);
    end
  endtask

  task automatic push_exit();
    push_run(2'b00, c_t_lpx);
    push_run(2'b10, c_t_lpx);
  endtask

  task automatic check_run(input logic [1:0] lvl, input int len);
    run_t r;
    if (exp_q.size() == 0) begin
      chk("run_unexpected_lvl", {30'd0, lvl}, 32'h3);
    end else begin
      r = exp_q.pop_front();
      chk($sformatf("run_lvl@%0d", cyc), {30'd0, lvl}, {30'd0, r.lvl});
      chk($sformatf("run_len@%0d", cyc), len, {16'd0, r.len});
    end
  endtask

  // Line-run monitor; LP-11 runs are idle/STOP and are not scored
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      cur_lvl = 2'b11;
      cur_len = 0;
    end else if ({lp_p, lp_n} == cur_lvl) begin
      cur_len++;
    end else begin
      if (cur_lvl != 2'b11) check_run(cur_lvl, cur_len);
      cur_lvl = {lp_p, lp_n};
      cur_len = 1;
    end
    if (err_underrun === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (watch_ready && tx_ready === 1'b1) ready_hi = 1'b1;
  end

  // Called at a negedge while the lane is in STOP
  task automatic do_start(input logic [1:0] sel, input logic [7:0] user);
    logic [7:0] c;
    case (sel)
      2'd0:    c = 8'b11100001;
      2'd1:    c = 8'b00011110;
      2'd2:    c = 8'b01100010;
      default: c = user;
    endcase
    cmd_sel = sel;
    cmd_user = user;
    start = 1'b1;
    push_run(2'b10, c_t_lpx);
    push_run(2'b00, c_t_lpx);
    push_run(2'b01, c_t_lpx);
    push_run(2'b00, c_t_lpx);
    push_byte(c);
    @(negedge clk_sys);
    start = 1'b0;
    t_start = cyc;
    cmd_sel = ~sel;
    cmd_user = ~user;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    tx_data = d;
    tx_last = last;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("send_timeout", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    push_byte(d);
    @(negedge clk_sys);
    tx_valid = 1'b0;
    tx_last = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int t_ref, input int exp_lat);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_done_lat"}, (done === 1'b1) ? (cyc - t_ref) : -1, exp_lat);
    chk({tag, "_done_lines"}, {29'd0, lp_oe, lp_p, lp_n}, 32'd7);
    @(negedge clk_sys);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    int t_w;

    // reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_lines", {30'd0, lp_p, lp_n}, 32'd3);
    chk("rst_oe", {31'd0, lp_oe}, 32'd0);
    chk("rst_flags", {27'd0, tx_ready, busy, in_ulps, done, err_underrun}, 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("stop_oe", {30'd0, lp_oe, busy}, 32'd2);

    // single-byte LPDT
    e0 = err_cnt;
    do_start(2'd0, 8'd0);
    send_byte(8'hA5, 1'b1);
    push_exit();
    wait_done("lpdt1", t_start, 152);
    chk("lpdt1_err", err_cnt - e0, 0);

    // back-to-back LPDT
    e0 = err_cnt;
    do_start(2'd0, 8'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h3C, 1'b1);
    push_exit();
    chk("b2b_ready_after_last", {31'd0, tx_ready}, 32'd0);
    ready_hi = 1'b0;
    watch_ready = 1'b1;
    wait_done("b2b", t_start, 16 + 64 + 3 * 64 + 8);
    watch_ready = 1'b0;
    chk("b2b_ready_stays_low", {31'd0, ready_hi}, 32'd0);
    chk("b2b_err", err_cnt - e0, 0);

    // underrun after first byte
    e0 = err_cnt;
    do_start(2'd0, 8'd0);
    send_byte(8'h5A, 1'b0);
    push_exit();
    wait_done("undr", t_start, 152);
    chk("undr_err_cnt", err_cnt - e0, 1);
    chk("undr_err_time", err_cyc - t_start, 144);

    // ULPS round trip
    do_start(2'd1, 8'd0);
    n = 0;
    while (in_ulps !== 1'b1 && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk("ulps_entry_lat", cyc - t_start, 80);
    chk("ulps_lines", {30'd0, lp_p, lp_n}, 32'd0);
    start = 1'b1;
    enable = 1'b0;
    @(negedge clk_sys);
    start = 1'b0;
    enable = 1'b1;
    chk("ulps_ignores_start_enable", {30'd0, in_ulps, lp_oe}, 32'd3);
    repeat (48) @(negedge clk_sys);
    ulps_exit = 1'b1;
    push_run(2'b00, 50);
    push_run(2'b10, c_t_wake);
    @(negedge clk_sys);
    ulps_exit = 1'b0;
    t_w = cyc;
    chk("wake_state", {29'd0, in_ulps, lp_p, lp_n}, 32'd2);
    wait_done("wake", t_w, c_t_wake);

    // Reset-Trigger: no payload handshake
    ready_hi = 1'b0;
    watch_ready = 1'b1;
    do_start(2'd2, 8'd0);
    push_exit();
    wait_done("rtrig", t_start, 88);
    chk("rtrig_no_ready", {31'd0, ready_hi}, 32'd0);

    // user command
    ready_hi = 1'b0;
    do_start(2'd3, 8'h81);
    push_exit();
    wait_done("user", t_start, 88);
    watch_ready = 1'b0;
    chk("user_no_ready", {31'd0, ready_hi}, 32'd0);

    // asynchronous reset mid-CMD
    do_start(2'd0, 8'd0);
    repeat (25) @(negedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_lines", {29'd0, lp_oe, lp_p, lp_n}, 32'd3);
    chk("rst_mid_flags", {30'd0, busy, tx_ready}, 32'd0);
    @(negedge clk_sys);
    exp_q.delete();
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_mid_recover", {29'd0, lp_oe, busy, done}, 32'd4);

    // enable low with start in STOP
    enable = 1'b0;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    chk("dis_prio", {30'd0, lp_oe, busy}, 32'd0);
    @(negedge clk_sys);
    chk("dis_hold", {30'd0, lp_oe, busy}, 32'd0);
    enable = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("dis_reenable", {30'd0, lp_oe, busy}, 32'd2);

    // enable low during DATA
    do_start(2'd0, 8'd0);
    send_byte(8'hC3, 1'b1);
    push_exit();
    repeat (70) @(negedge clk_sys);
    enable = 1'b0;
    @(negedge clk_sys);
    chk("dis_mid_busy", {31'd0, busy}, 32'd1);
    wait_done("dis_mid", t_start, 152);
    chk("dis_mid_after", {30'd0, lp_oe, busy}, 32'd0);
    enable = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsi_lp_escape_lane.md
Name: dsi_lp_escape_lane

Overview:
Parametrised low-power (LP) escape-mode transmitter for one D-PHY data lane. From the LP-11 Stop state it drives the full escape sequence: entry, an 8-bit entry command, optional LPDT payload bytes with a valid/ready handshake, then exit.
- Supports LPDT, ULPS (with wake-up), Reset-Trigger and a user-defined entry command.
- Encodes all bits as spaced-one-hot, with a programmable LP state duration.
- Sits beside the HS lane serializer, which owns the lane only while lp_oe=0.

Parameters:
T_LPX_CYC, 4, clk_sys cycles each LP line state is held; legal range 2..255.
T_WAKEUP_CYC, 16, clk_sys cycles LP-10 is held on ULPS exit; legal range 1..65535.
CMD_LPDT, 8'b11100001, LPDT entry command; bit7 is sent first.
CMD_ULPS, 8'b00011110, ULPS entry command.
CMD_RESET_TRIG, 8'b01100010, Reset-Trigger entry command.

Ports:
clk_sys  in  1  LP logic clock
rst_n  in  1  reset
enable  in  1  lane enable; low in STOP moves the block to DISABLED
start  in  1  request an escape sequence; sampled only in STOP
cmd_sel  in  2  entry command select: 0 LPDT, 1 ULPS, 2 Reset-Trigger, 3 user
cmd_user  in  8  entry command used when cmd_sel=3
ulps_exit  in  1  request wake-up; sampled only in ULPS
tx_data  in  8  LPDT payload byte
tx_valid  in  1  tx_data is valid
tx_last  in  1  qualifies the final payload byte
tx_ready  out  1  block accepts a byte; transfer occurs when tx_valid && tx_ready
busy  out  1  high in every state except DISABLED and STOP
in_ulps  out  1  high while in ULPS
done  out  1  one-cycle pulse when the block returns to STOP
err_underrun  out  1  one-cycle pulse when the payload underruns
lp_p  out  1  LP Dp line level
lp_n  out  1  LP Dn line level
lp_oe  out  1  LP driver enable

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_sys. On reset, in any state including mid-sequence: state=DISABLED, lp_p=1, lp_n=1, lp_oe=0, tx_ready=0, busy=0, in_ulps=0, done=0, err_underrun=0, holding register empty. All outputs are registered.
- Line state notation: LP-xy means lp_p=x, lp_n=y. Every state ("phase") below is held exactly T_LPX_CYC cycles, except ULPS (indefinite) and WAKE (T_WAKEUP_CYC). A single phase counter is reloaded at each phase boundary.
- Command latch: cmd_sel and cmd_user are latched on start acceptance; later changes have no effect.
- DISABLED: lp_oe=0.
  - enable=1 -> STOP.
- STOP: LP-11, lp_oe=1.
  - enable=0 -> DISABLED. This takes priority over start.
  - start=1 -> ESC_ENTRY; the first phase is visible on the lines the following cycle.
- ESC_ENTRY: four phases, LP-10, LP-00, LP-01, LP-00, then -> CMD.
- CMD: 8 bits, bit7 first. Each bit is two phases:
  - mark: LP-10 for a 1, LP-01 for a 0;
  - space: LP-00.
  - After the last space: LPDT -> DATA; ULPS -> ULPS; all other commands -> EXIT.
- DATA: each byte is encoded exactly as in CMD. A byte is loaded from the 1-entry holding register at each byte boundary.
- tx_ready: high whenever the holding register is empty, in CMD with LPDT latched or in DATA. It is never high in other states.
- Holding register fill: an accepted byte fills the register on the same edge.
- Byte boundary, no stored last:
  - Holding register empty: err_underrun pulses for 1 cycle -> EXIT. No byte is transmitted.
  - Holding register full: its byte is loaded and transmitted.
- tx_last: after the byte stored with tx_last=1 has been sent -> EXIT. tx_ready stays low from acceptance of the last byte until STOP.
- Simultaneous accept and load: the holding register empties on the same edge it is loaded into the shifter, and can be refilled the next cycle.
- EXIT: two phases, LP-00 then LP-10, then -> STOP. done pulses on the cycle STOP is entered, with lines at LP-11.
- ULPS: LP-00, in_ulps=1.
  - ulps_exit=1 -> WAKE.
  - enable and start are ignored.
- WAKE: LP-10 for T_WAKEUP_CYC cycles -> STOP, in_ulps=0, done pulses.
- enable=0 mid-sequence is ignored until STOP is reached.
- start while busy is ignored.
- Counter widths: phase counter 8 bits; wake counter 16 bits; bit counter 3 bits, wrapping 7->0 at each byte boundary.

Test Plan:
- Single-byte LPDT: T_LPX_CYC=4, cmd_sel=0, start, then one byte 0xA5 with tx_last=1 -> lines show 10,00,01,00; then the E1 bit pattern; then A5 marks 10,01,10,01,01,10,01,10, each followed by 00; then 00,10,11. done pulses exactly 152 cycles after start acceptance.
- Back-to-back LPDT: bytes 0x00, 0xFF, 0x3C with tx_valid held high, last on 0x3C -> no gaps between bytes, 3×64 data cycles, err_underrun never asserts, tx_ready low after the third acceptance.
- Underrun: LPDT with first byte sent and tx_valid held low -> err_underrun pulses at the end of the first byte; EXIT sequence follows; done pulses 8 cycles later.
- ULPS round trip: cmd_sel=1 -> lines LP-00 with in_ulps=1 after 80 cycles; ulps_exit after 50 cycles -> LP-10 for 16 cycles, then LP-11, in_ulps=0, done=1.
- Reset-Trigger and user command: cmd_sel=2 -> pattern 01100010 then EXIT with no tx_ready. cmd_sel=3, cmd_user=0x81 -> marks 10, 01×6, 10.
- Reset and enable: assert rst_n=0 mid-CMD -> next-cycle outputs LP-11, lp_oe=0, busy=0. enable=0 together with start in STOP -> DISABLED, no sequence. enable=0 during DATA -> sequence completes, then DISABLED.
